// File: rtl/inst_fifo.sv
// Instruction ingress buffer: packs three 32-bit host words into one 82-bit
// instruction and queues instructions in a first-word-fall-through FIFO.
module inst_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     flush,
    input  logic [31:0]              host_wdata,
    input  logic                     host_wvalid,
    output logic                     host_wready,
    input  logic                     read_en,
    output logic [81:0]              fifo_data,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        WC_LO  = 2'd0,
        WC_MID = 2'd1,
        WC_HI  = 2'd2
    } wc_e;

    wc_e           wc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [63:0]   staging;
    logic          unf;
    logic [81:0]   mem [DEPTH];

    logic accept;
    logic push;
    logic pop;

    // Only the closing word of an instruction needs FIFO space.
    assign host_wready = (wc != WC_HI) || (cnt < FULL_CNT);
    assign accept      = host_wvalid && host_wready;
    assign push        = accept && (wc == WC_HI);
    assign pop         = read_en && !fifo_empty;

    assign fifo_empty  = (cnt == '0);
    assign fifo_full   = (cnt == FULL_CNT);
    assign count       = cnt;
    assign underflow   = unf;
    assign fifo_data   = fifo_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (n_rst) begin
            wc      <= WC_LO;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            staging <= '0;
            unf     <= 1'b0;
        end else if (flush) begin
            wc      <= WC_LO;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            staging <= '0;
            unf     <= 1'b0;
        end else begin
            if (accept) begin
                case (wc)
                    WC_LO: begin
                        staging[31:0] <= host_wdata;
                        wc            <= WC_MID;
                    end
                    WC_MID: begin
                        staging[63:32] <= host_wdata;
                        wc             <= WC_HI;
                    end
                    default: wc <= WC_LO;
                endcase
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (read_en && fifo_empty) unf <= 1'b1;
        end
    end

    // Storage has no reset; the gating keeps discarded pushes out of the array.
    always_ff @(posedge clk) begin
        if (!n_rst && !flush && push) mem[wr_ptr] <= {host_wdata[17:0], staging};
    end

endmodule

// File: doc/inst_fifo.md
# inst_fifo

Instruction ingress buffer directly upstream of the alpha/fill/BLA wrapper. It accepts 32-bit command words from the host interface and packs every three words into one 82-bit instruction. It queues the instructions in a DEPTH-entry first-word-fall-through FIFO. The head entry is presented as `fifo_data` to the decode stage and popped by the main controller's `read_en`.

## Interface
- `DEPTH`, 8, number of 82-bit instruction entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `n_rst`  in  1  synchronous, active-high reset (1 = reset, sampled on `clk` edge).
- `flush`  in  1  synchronous clear of the FIFO and of any partially packed instruction.
- `host_wdata`  in  32  command word from host.
- `host_wvalid`  in  1  host word valid.
- `host_wready`  out  1  block can accept a word this cycle.
- `read_en`  in  1  pop head entry (from main controller).
- `fifo_data`  out  82  head instruction; FWFT.
- `fifo_empty`  out  1  no complete instruction stored.
- `fifo_full`  out  1  DEPTH entries stored.
- `count`  out  $clog2(DEPTH)+1  stored entry count.
- `underflow`  out  1  sticky: `read_en` seen while empty.

## Operation
- Word handshake: a word is accepted when `host_wvalid && host_wready`.
- Packing: a 2-bit word counter `wc` is stepped 0→1→2→0 on each accepted word.
  - wc=0: word goes to staging[31:0].
  - wc=1: word goes to staging[63:32].
  - wc=2: `host_wdata[17:0]` is placed in bits [81:64]. The full 82-bit word {wdata[17:0], staging[63:0]} is written to mem[wr_ptr] in the same edge. `host_wdata[31:18]` is ignored.
- `host_wready` = (wc != 2) || (count < DEPTH). It is purely registered-state based, with no combinational path from `read_en`.
- Pop: `read_en && !fifo_empty` advances rd_ptr. `read_en` while empty is ignored and sets `underflow`, which is cleared only by `n_rst` or `flush`.
- Simultaneous push and pop: both happen and count is unchanged. This is legal at any non-empty count below DEPTH. At count = DEPTH the push cannot occur because `host_wready` = 0 when wc = 2.
- Pointers: $clog2(DEPTH)-bit counters that wrap modulo DEPTH. count is 0..DEPTH.
- Status decodes:
  - `fifo_empty` = (count == 0).
  - `fifo_full` = (count == DEPTH).
  - `fifo_data` = mem[rd_ptr] when not empty, else 82'd0.
- Precedence: `n_rst` > `flush` > normal operation.
  - `flush` zeroes pointers, count, wc, staging and `underflow`.
  - Words, pushes and pops offered in the flush cycle are discarded.
  - Memory contents need not be cleared.

## Timing
- Reset values:
  - `host_wready`=1, `fifo_empty`=1, `fifo_full`=0, `count`=0, `underflow`=0, `fifo_data`=0.
  - Internal: wc=0, pointers=0.
- Latency: third word accepted at edge N → `fifo_empty`=0, `count`=1 and `fifo_data` valid in the cycle after edge N.
- Pop at edge N → next entry (or 0 if now empty) on `fifo_data` after edge N.
- Reset or flush mid-packing discards the partial instruction. The next accepted word is treated as wc=0.
- Throughput: one word per cycle sustained while not full, i.e. one instruction per 3 cycles.

## Test plan
- Reset then 3 words 0x11111111, 0x22222222, 0xFFFFFFC5 → one cycle later `fifo_empty`=0, `count`=1, `fifo_data`=82'h3FFC5_22222222_11111111. Then `read_en` for one cycle → `fifo_empty`=1, `fifo_data`=0.
- Fill: push 8 instructions (word0 = index 0..7), no pops → `fifo_full`=1 and `count`=8. Also:
  - The 3rd word of a 9th instruction is held, with `host_wready`=0 while wc=2.
  - Words 1–2 of the 9th instruction are still accepted.
  - After one pop, the held word completes, `count` returns to 8, and pops yield indices 1..8 in order.
- Wrap: 20 instructions streamed with a pop every 4th cycle → all 20 are emerge in order with no loss. `count` never exceeds 8, and pointers wrap correctly.
- Simultaneous: at count=3, the third word and `read_en` arrive in the same cycle → count stays 3, the head advances and the new entry lands at the tail.
- Underflow: `read_en`=1 while empty → `count` stays 0 and `underflow`=1 persists. It clears after `flush`=1 for one cycle.
- Mid-operation: 2 words accepted, then `n_rst`=1 for one cycle, then 3 new words A, B, C → exactly one entry {C[17:0],B,A}. Repeat the sequence using `flush` instead of `n_rst` with 5 entries queued → `count`=0 after the flush cycle.
